// File: rtl/text_char_renderer.sv
// Character-cell text renderer: a 3-stage pixel pipeline that turns timing-generator coordinates into RGB.
// Define TEXT_CURSOR_EN to enable the blinking underline cursor. The default build has no cursor.
module text_char_renderer #(
   parameter int          COLS         = 80,
   parameter int          ROWS         = 30,
   parameter int          ADDR_W       = 12,
   parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
   parameter logic [23:0] BG_RGB       = 24'h000000,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_de,
   input  logic              in_hs,
   input  logic              in_vs,
   input  logic [10:0]       in_x,
   input  logic [9:0]        in_y,
   output logic              txt_rd_en,
   output logic [ADDR_W-1:0] txt_addr,
   input  logic [7:0]        txt_data,
   output logic [7:0]        font_ascii,
   output logic [3:0]        font_row,
   input  logic [7:0]        font_data,
   input  logic [6:0]        cur_col,
   input  logic [4:0]        cur_row,
   output logic              out_de,
   output logic              out_hs,
   output logic              out_vs,
   output logic [23:0]       out_rgb
);

   logic        w_in_area;
   logic [31:0] w_addr_full;

   logic        r_de1;
   logic        r_hs1;
   logic        r_vs1;
   logic        r_area1;
   logic [2:0]  r_col1;
   logic [3:0]  r_row1;
   logic [7:0]  w_bmp1;

   logic        r_de2;
   logic        r_hs2;
   logic        r_vs2;
   logic        r_area2;
   logic [2:0]  r_col2;
   logic [7:0]  r_bmp2;
   logic        w_bit;
   logic [23:0] w_rgb;

   assign w_in_area   = ({21'd0, in_x} < 32'(COLS * 8)) && ({22'd0, in_y} < 32'(ROWS * 16));
   assign w_addr_full = ({26'd0, in_y[9:4]} * 32'(COLS)) + {24'd0, in_x[10:3]};

   // The read strobe and address are combinational from the inputs. They are gated by reset
   // so that they go to zero at once when reset is asserted in the middle of a line.
   assign txt_rd_en = rst_n & in_de & w_in_area;
   assign txt_addr  = rst_n ? w_addr_full[ADDR_W-1:0] : '0;

   assign font_ascii = r_area1 ? txt_data : 8'h00;
   assign font_row   = r_row1;

`ifdef TEXT_CURSOR_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic             w_cur_cell;
   logic             r_cur1;
   logic             r_vs_prev;
   logic             r_blink_on;
   logic [CNT_W-1:0] r_frame_cnt;

   assign w_cur_cell = (in_x[10:3] == {1'b0, cur_col}) && (in_y[9:4] == {1'b0, cur_row});
   assign w_bmp1     = (r_blink_on && r_cur1 && (r_row1 >= 4'd14)) ? 8'hFF : font_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur1      <= 1'b0;
         r_vs_prev   <= 1'b0;
         r_blink_on  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_cur1    <= w_cur_cell;
         r_vs_prev <= in_vs;
         if (in_vs && !r_vs_prev) begin
            if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
               r_frame_cnt <= '0;
               r_blink_on  <= ~r_blink_on;
            end else begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end
         end
      end
   end
`else
   logic w_unused_cursor;

   assign w_bmp1          = font_data;
   assign w_unused_cursor = ^{cur_col, cur_row, (BLINK_FRAMES != 0)};
`endif

   assign w_bit = r_bmp2[3'd7 - r_col2];
   assign w_rgb = (r_de2 && r_area2) ? (w_bit ? FG_RGB : BG_RGB) : 24'h000000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_de1   <= 1'b0;
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
         r_area1 <= 1'b0;
         r_col1  <= 3'd0;
         r_row1  <= 4'd0;
         r_de2   <= 1'b0;
         r_hs2   <= 1'b0;
         r_vs2   <= 1'b0;
         r_area2 <= 1'b0;
         r_col2  <= 3'd0;
         r_bmp2  <= 8'h00;
         out_de  <= 1'b0;
         out_hs  <= 1'b0;
         out_vs  <= 1'b0;
         out_rgb <= 24'h000000;
      end else begin
         r_de1   <= in_de;
         r_hs1   <= in_hs;
         r_vs1   <= in_vs;
         r_area1 <= w_in_area;
         r_col1  <= in_x[2:0];
         r_row1  <= in_y[3:0];
         r_de2   <= r_de1;
         r_hs2   <= r_hs1;
         r_vs2   <= r_vs1;
         r_area2 <= r_area1;
         r_col2  <= r_col1;
         r_bmp2  <= w_bmp1;
         out_de  <= r_de2;
         out_hs  <= r_hs2;
         out_vs  <= r_vs2;
         out_rgb <= w_rgb;
      end
   end

endmodule

// File: tb/tb_text_char_renderer.sv
// Bench for text_char_renderer: it holds a text RAM and a font ROM, and compares the DUT every cycle against a pixel-level model.
// The cursor checks are compiled in only when TEXT_CURSOR_EN is defined.
module tb_text_char_renderer;

   localparam int          COLS = 80;
   localparam int          ROWS = 30;
   localparam int          AW   = 12;
   localparam logic [23:0] FG   = 24'hF0E0D0;
   localparam logic [23:0] BG   = 24'h102030;
   localparam int          BF   = 2;

   logic          clk;
   logic          rst_n;
   logic          in_de;
   logic          in_hs;
   logic          in_vs;
   logic [10:0]   in_x;
   logic [9:0]    in_y;
   logic          txt_rd_en;
   logic [AW-1:0] txt_addr;
   logic [7:0]    txt_data;
   logic [7:0]    font_ascii;
   logic [3:0]    font_row;
   logic [7:0]    font_data;
   logic [6:0]    cur_col;
   logic [4:0]    cur_row;
   logic          out_de;
   logic          out_hs;
   logic          out_vs;
   logic [23:0]   out_rgb;

   text_char_renderer #(
      .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
      .in_x(in_x), .in_y(in_y), .txt_rd_en(txt_rd_en), .txt_addr(txt_addr),
      .txt_data(txt_data), .font_ascii(font_ascii), .font_row(font_row),
      .font_data(font_data), .cur_col(cur_col), .cur_row(cur_row),
      .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_rgb(out_rgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] ram [0:(1<<AW)-1];

   always @(posedge clk) if (txt_rd_en) txt_data <= ram[txt_addr];

   function automatic logic [7:0] font_fn(input logic [7:0] a, input logic [3:0] r);
      logic [7:0] t;
      if (a == 8'h00 || a == 8'h20) return 8'h00;
      if (a == 8'h41 && r == 4'd5) return 8'h7E;
      t = a * 8'd29;
      return t ^ {r, ~r} ^ 8'h33;
   endfunction

   assign font_data = font_fn(font_ascii, font_row);

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40) $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
   } exp_t;

   exp_t       q[$];
   exp_t       e_pop;
   exp_t       e_new;
   int         edges;
   logic       prev_vs;
   logic [3:0] prev_row;
   int         prev_kind;
   logic [7:0] prev_ascii;
   int         xi;
   int         yi;
   bit         area;
   bit         blink;

   function automatic logic [23:0] model_rgb(input bit de, input int x, input int y, input bit bl);
      logic [7:0] bmp;
      if (!de || x >= COLS * 8 || y >= ROWS * 16) return 24'h0;
      bmp = font_fn(ram[(y / 16) * COLS + x / 8], 4'(y % 16));
`ifdef TEXT_CURSOR_EN
      if (bl && (x / 8) == int'(cur_col) && (y / 16) == int'(cur_row) && (y % 16) >= 14) bmp = 8'hFF;
`else
      if (bl && 1'b0) bmp = 8'h00;
`endif
      return bmp[7 - (x % 8)] ? FG : BG;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q = {};
            repeat (3) q.push_back('0);
            edges = 0; prev_vs = 1'b0; prev_row = 4'd0; prev_kind = 0; prev_ascii = 8'h00;
            chk("rst_out_de", out_de, 0);
            chk("rst_out_hs", out_hs, 0);
            chk("rst_out_vs", out_vs, 0);
            chk("rst_out_rgb", out_rgb, 0);
            chk("rst_rd_en", txt_rd_en, 0);
            chk("rst_addr", txt_addr, 0);
            chk("rst_font_ascii", font_ascii, 0);
            chk("rst_font_row", font_row, 0);
         end else begin
            e_pop = q.pop_front();
            chk("out_de", out_de, e_pop.de);
            chk("out_hs", out_hs, e_pop.hs);
            chk("out_vs", out_vs, e_pop.vs);
            chk("out_rgb", out_rgb, e_pop.rgb);
            chk("font_row", font_row, prev_row);
            if (prev_kind != 2) chk("font_ascii", font_ascii, prev_ascii);

            xi = int'(in_x);
            yi = int'(in_y);
            area = (xi < COLS * 8) && (yi < ROWS * 16);
            chk("rd_en", txt_rd_en, in_de && area);
            if (in_de && area) chk("addr", txt_addr, (yi / 16) * COLS + xi / 8);

            if (in_vs && !prev_vs) edges++;
            prev_vs = in_vs;
            blink = ((edges / BF) % 2) == 1;
            e_new.de  = in_de;
            e_new.hs  = in_hs;
            e_new.vs  = in_vs;
            e_new.rgb = model_rgb(in_de, xi, yi, blink);
            q.push_back(e_new);

            prev_row = in_y[3:0];
            if (!area) begin
               prev_kind = 0; prev_ascii = 8'h00;
            end else if (in_de) begin
               prev_kind = 1; prev_ascii = ram[(yi / 16) * COLS + xi / 8];
            end else begin
               prev_kind = 2;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic put(input logic de, input logic hs, input logic vs, input int x, input int y);
      @(posedge clk);
      #1;
      in_de = de; in_hs = hs; in_vs = vs;
      in_x = 11'(x); in_y = 10'(y);
   endtask

   task automatic blank(input int n);
      repeat (n) put(1'b0, in_hs, in_vs, 0, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rgb", out_rgb, 0);
      chk("mid_rst_de", out_de, 0);
      chk("mid_rst_rd_en", txt_rd_en, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

`ifdef TEXT_CURSOR_EN
   task automatic vs_pulse();
      repeat (2) put(1'b0, in_hs, 1'b1, 0, 0);
      repeat (2) put(1'b0, in_hs, 1'b0, 0, 0);
   endtask

   task automatic cur_px(input string nm, input int x, input int y, input logic [23:0] exp);
      put(1'b1, in_hs, in_vs, x, y);
      blank(3);
      chk(nm, out_rgb, exp);
   endtask
`endif

   logic d_de;
   logic d_hs;
   int   d_x;
   int   d_y;

   initial begin
      #5_000_000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom);
      ram[0]  = 8'h41;
      ram[83] = 8'h20;
      rst_n = 1'b0; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; in_x = '0; in_y = '0;
      cur_col = 7'd3; cur_row = 5'd1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      blank(2);

`ifdef TEXT_CURSOR_EN
      cur_px("cur_e0", 26, 30, BG);
      vs_pulse();
      cur_px("cur_e1", 26, 30, BG);
      vs_pulse();
      cur_px("cur_e2_y30", 24, 30, FG);
      cur_px("cur_e2_y31", 31, 31, FG);
      cur_px("cur_e2_y29", 26, 29, BG);
      vs_pulse();
      cur_px("cur_e3", 28, 30, FG);
      vs_pulse();
      cur_px("cur_e4", 28, 30, BG);
`endif

      // Glyph 'A' row 5 across one cell: font row pattern 0x7E.
      for (int i = 0; i < 8; i++) begin
         put(1'b1, 1'b0, in_vs, i, 5);
         blank(1);
         chk("s1_font_ascii", font_ascii, 8'h41);
         chk("s1_font_row", font_row, 4'd5);
         blank(2);
         chk("glyph_px", out_rgb, (i == 0 || i == 7) ? BG : FG);
      end

      put(1'b1, 1'b0, in_vs, 639, 479);
      #1;
      chk("addr_639_479", txt_addr, 2399);
      chk("rd_en_639_479", txt_rd_en, 1);
      put(1'b1, 1'b0, in_vs, 8, 16);
      #1;
      chk("addr_8_16", txt_addr, 81);
      put(1'b1, 1'b0, in_vs, 640, 100);
      #1;
      chk("rd_en_x640", txt_rd_en, 0);
      blank(3);
      chk("rgb_x640", out_rgb, 0);
      put(1'b0, 1'b0, in_vs, 100, 100);
      blank(3);
      chk("rgb_de0", out_rgb, 0);

      // Sync toggles appear exactly three clocks later.
      put(1'b1, 1'b1, ~in_vs, 10, 10);
      blank(2);
      chk("hs_lat2", out_hs, 0);
      chk("de_lat2", out_de, 0);
      blank(1);
      chk("hs_lat3", out_hs, 1);
      chk("de_lat3", out_de, 1);
      put(1'b0, 1'b0, ~in_vs, 0, 0);
      blank(5);

      for (int it = 0; it < 3000; it++) begin
         if (it == 1500) begin
            put(1'b1, in_hs, in_vs, 100, 100);
            do_reset();
         end
         if ($urandom_range(0, 39) == 0) begin
            blank(3);
            put(1'b0, in_hs, ~in_vs, 0, 0);
            blank(3);
         end else begin
            d_de = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
               0: begin d_x = int'($urandom_range(0, 2047)); d_y = int'($urandom_range(0, 1023)); end
               1: begin d_x = int'($urandom_range(16, 40));  d_y = int'($urandom_range(12, 36));  end
               default: begin d_x = int'($urandom_range(0, 660)); d_y = int'($urandom_range(0, 490)); end
            endcase
            d_hs = ($urandom_range(0, 15) == 0) ? ~in_hs : in_hs;
            put(d_de, d_hs, in_vs, d_x, d_y);
         end
      end
      blank(5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/text_char_renderer.md
Name: text_char_renderer

Overview:
- Character-cell text renderer on the HDMI/VGA pixel path.
- Consumes pixel coordinates and timing strobes from the video timing generator.
- Reads ASCII codes from the text buffer RAM, drives the 8x16 combinational font ROM (ascii + row in, 8-bit row bitmap out), and serialises the bitmap into RGB pixels.
- Sits between the timing generator and the TMDS encoder, in the pixel clock domain.

Parameters:
- COLS, 80, text columns (cell width fixed at 8 px).
- ROWS, 30, text rows (cell height fixed at 16 px).
- ADDR_W, 12, text RAM address width; must satisfy COLS*ROWS <= 2^ADDR_W.
- FG_RGB, 24'hFFFFFF, foreground colour.
- BG_RGB, 24'h000000, background colour inside the text area.
- BLINK_FRAMES, 30, cursor blink half-period in frames (optional feature only).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- in_de  in  1  active video from timing generator
- in_hs  in  1  hsync (polarity passed through unchanged)
- in_vs  in  1  vsync (polarity passed through unchanged)
- in_x  in  11  pixel column, valid when in_de=1
- in_y  in  10  pixel line, valid when in_de=1
- txt_rd_en  out  1  text RAM read enable
- txt_addr  out  ADDR_W  text RAM address = (in_y>>4)*COLS + (in_x>>3)
- txt_data  in  8  ASCII code; valid exactly 1 cycle after txt_rd_en
- font_ascii  out  8  to font ROM
- font_row  out  4  glyph row to font ROM (0..15)
- font_data  in  8  glyph row bitmap from font ROM, combinational; bit7 = leftmost pixel
- cur_col  in  7  cursor column (optional feature)
- cur_row  in  5  cursor row (optional feature)
- out_de  out  1  delayed in_de
- out_hs  out  1  delayed in_hs
- out_vs  out  1  delayed in_vs
- out_rgb  out  24  pixel colour

Behaviour:
- Reset: all pipeline registers and outputs are 0 (out_de=0, out_hs=0, out_vs=0, out_rgb=0, txt_rd_en=0, txt_addr=0, font_ascii=0, font_row=0). Reset is asynchronous assert and takes effect mid-line.
- Pipeline, fixed 3-cycle latency from in_* to out_*. out_de/out_hs/out_vs equal in_de/in_hs/in_vs delayed by exactly 3 clocks.
- S0 (combinational from inputs):
  - txt_rd_en = in_de & in_area, where in_area = (in_x < COLS*8) & (in_y < ROWS*16).
  - txt_addr is driven from the coordinates.
  - col[2:0] = in_x[2:0], row[3:0] = in_y[3:0], de, area, hs and vs are registered into stage 1.
- S1: txt_data arrives.
  - font_ascii = area1 ? txt_data : 8'h00. Code 00 renders blank.
  - font_row = row1.
  - font_data returns in the same cycle.
  - font_data is registered with col, de, area, hs and vs into stage 2.
- S2: bit = bmp2[7 - col2].
  - out_rgb = !de2 ? 0 : !area2 ? 0 : (bit ? FG_RGB : BG_RGB).
  - Registered into the output stage.
- Address arithmetic: the multiply is (in_y>>4)*COLS, truncated to ADDR_W. Out-of-area coordinates may produce any address, but txt_rd_en is 0 for them.
- Undefined glyphs: codes the font ROM does not define render its box pattern verbatim. No filtering is done in this block.
- No backpressure: one pixel in and one pixel out every clock.

Optional Feature:
- Macro: TEXT_CURSOR_EN
- Defined:
  - A frame counter increments on each rising edge of in_vs and wraps at BLINK_FRAMES-1.
  - blink_on toggles on each wrap. Counter and blink_on reset to 0.
  - When blink_on=1, the cell at (cur_col, cur_row) has glyph rows 14 and 15 forced to 8'hFF before bit selection. This gives an underline cursor.
  - Latency is unchanged.
- Undefined: cur_col and cur_row are ignored, there is no counter logic, and the cursor is never drawn.

Test Plan:
- Latency/sync: toggle in_hs and in_vs at a known cycle -> out_hs/out_vs toggle exactly 3 cycles later. out_de tracks in_de with the same 3-cycle delay.
- Glyph render: RAM[0]=8'h41 ('A'), y=5, x=0..7 with font model row5=8'h7E -> out_rgb = BG,FG,FG,FG,FG,FG,FG,BG. font_ascii=8'h41 and font_row=5 on the S1 cycle.
- Addressing: x=639, y=479 -> txt_addr=2399, txt_rd_en=1. x=8, y=16 -> txt_addr=81.
- Out of area / blanking: COLS=80, x=640, de=1 -> txt_rd_en=0, out_rgb=0. in_de=0 anywhere -> out_rgb=0.
- Reset mid-line: assert rst_n=0 during active video -> all outputs 0 immediately. Release -> first non-zero out_rgb no earlier than 3 cycles after the first in_de=1.
- Cursor (TEXT_CURSOR_EN, BLINK_FRAMES=2): cur=(3,1), RAM[83]=8'h20 -> rows 30-31 at x=24..31 are FG while blink_on=1. They are BG in the alternating frame pair, toggling every 2 vsync edges.
